// File: rtl/actuator_pkg.sv
// Shared code points and motor FSM states for the actuator driver.
package actuator_pkg;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] L1 = 3'b001;
    localparam logic [2:0] L2 = 3'b010;
    localparam logic [2:0] L3 = 3'b011;
    localparam logic [2:0] R1 = 3'b100;
    localparam logic [2:0] R2 = 3'b101;
    localparam logic [2:0] R3 = 3'b110;
    localparam logic [2:0] RE = 3'b111;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] F1   = 2'b01;
    localparam logic [1:0] F2   = 2'b11;
    localparam logic [1:0] B1   = 2'b10;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RUN  = 2'd1,
        M_DEAD = 2'd2
    } motor_state_e;

endpackage

// File: rtl/actuator_driver_servo_channel.sv
// One servo output: position-code decode, sticky illegal-code fault, per-frame width update, pulse compare.
// ACT_SLEW_EN defined: width moves toward target by at most SLEW_CYC per frame.
module servo_channel
    import actuator_pkg::*;
#(
    parameter int PERIOD_CYC = 1000000,
    parameter int CENTER_CYC = 75000,
    parameter int STEP_CYC   = 12500,
    parameter int SLEW_CYC   = 2500,
    parameter int W          = $clog2(PERIOD_CYC + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_i,
    input  logic [W-1:0] cnt_i,
    input  logic [2:0]   code_i,
    output logic         pwm_o,
    output logic         fault_o
);

    localparam logic [W-1:0] CENTER_W = W'(CENTER_CYC);
    localparam logic [W-1:0] STEP1_W  = W'(STEP_CYC);
    localparam logic [W-1:0] STEP2_W  = W'(2 * STEP_CYC);
    localparam logic [W-1:0] STEP3_W  = W'(3 * STEP_CYC);
`ifdef ACT_SLEW_EN
    localparam logic [W-1:0] SLEW_W   = W'(SLEW_CYC);
`endif

    if (SLEW_CYC < 1) begin : g_bad_slew
        $error("servo_channel: SLEW_CYC must be at least 1");
    end

    logic [W-1:0] tgt_q, tgt_d;
    logic [W-1:0] cur_q, cur_d;
    logic         fault_q, fault_d;
    logic         pwm_q, pwm_d;

    always_comb begin
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        fault_d = fault_q;
        if (tick_i) begin
            case (code_i)
                S0:      tgt_d = CENTER_W;
                L1:      tgt_d = CENTER_W - STEP1_W;
                L2:      tgt_d = CENTER_W - STEP2_W;
                L3:      tgt_d = CENTER_W - STEP3_W;
                R1:      tgt_d = CENTER_W + STEP1_W;
                R2:      tgt_d = CENTER_W + STEP2_W;
                R3:      tgt_d = CENTER_W + STEP3_W;
                default: fault_d = 1'b1;  // RE: previous target is held
            endcase
`ifdef ACT_SLEW_EN
            if (tgt_d > cur_q)
                cur_d = (tgt_d - cur_q > SLEW_W) ? cur_q + SLEW_W : tgt_d;
            else
                cur_d = (cur_q - tgt_d > SLEW_W) ? cur_q - SLEW_W : tgt_d;
`else
            cur_d = tgt_d;
`endif
        end
        // Compare against the freshly updated width so the new value governs the pulse starting now.
        pwm_d = (cnt_i < cur_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_q   <= CENTER_W;
            cur_q   <= CENTER_W;
            fault_q <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            fault_q <= fault_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/actuator_driver.sv
// Drives two servo PWM pins and a motor PWM/direction pair from operator-input state codes.
// ACT_SLEW_EN defined: servo widths are slew-limited per frame; undefined: widths jump to target.
module actuator_driver
    import actuator_pkg::*;
#(
    parameter int PERIOD_CYC       = 1000000,
    parameter int CENTER_CYC       = 75000,
    parameter int STEP_CYC         = 12500,
    parameter int SLEW_CYC         = 2500,
    parameter int MOTOR_PERIOD_CYC = 1000,
    parameter int DEADTIME_CYC     = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] left_right,
    input  logic [2:0] up_down,
    input  logic [1:0] forward_backward,
    output logic       servo_lr,
    output logic       servo_ud,
    output logic       motor_pwm,
    output logic       motor_dir,
    output logic       fault,
    output logic       frame_tick
);

    localparam int SW = $clog2(PERIOD_CYC + 1);
    localparam int MW = $clog2(MOTOR_PERIOD_CYC + 1);
    localparam int DW = $clog2(DEADTIME_CYC + 1);

    localparam logic [SW-1:0] FRAME_LAST = SW'(PERIOD_CYC - 1);
    localparam logic [MW-1:0] MPER_LAST  = MW'(MOTOR_PERIOD_CYC - 1);
    localparam logic [MW-1:0] DUTY_HALF  = MW'(MOTOR_PERIOD_CYC / 2);
    localparam logic [MW-1:0] DUTY_FULL  = MW'(MOTOR_PERIOD_CYC);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME_CYC - 1);

    if (CENTER_CYC - 3 * STEP_CYC <= 0 || CENTER_CYC + 3 * STEP_CYC >= PERIOD_CYC) begin : g_bad_width
        $error("actuator_driver: CENTER_CYC +/- 3*STEP_CYC must lie strictly inside (0, PERIOD_CYC)");
    end
    if (DEADTIME_CYC < 1 || MOTOR_PERIOD_CYC < 2) begin : g_bad_motor
        $error("actuator_driver: DEADTIME_CYC >= 1 and MOTOR_PERIOD_CYC >= 2 required");
    end

    // Servo frame counter
    logic [SW-1:0] fcnt_q, fcnt_d;
    logic          tick, tick_q;

    assign tick   = (fcnt_q == '0);
    assign fcnt_d = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            tick_q <= tick;
        end
    end

    logic fault_lr, fault_ud;

    servo_channel #(
        .PERIOD_CYC (PERIOD_CYC),
        .CENTER_CYC (CENTER_CYC),
        .STEP_CYC   (STEP_CYC),
        .SLEW_CYC   (SLEW_CYC),
        .W          (SW)
    ) u_lr (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (tick),
        .cnt_i   (fcnt_q),
        .code_i  (left_right),
        .pwm_o   (servo_lr),
        .fault_o (fault_lr)
    );

    servo_channel #(
        .PERIOD_CYC (PERIOD_CYC),
        .CENTER_CYC (CENTER_CYC),
        .STEP_CYC   (STEP_CYC),
        .SLEW_CYC   (SLEW_CYC),
        .W          (SW)
    ) u_ud (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (tick),
        .cnt_i   (fcnt_q),
        .code_i  (up_down),
        .pwm_o   (servo_ud),
        .fault_o (fault_ud)
    );

    // Motor PWM and direction FSM
    logic [MW-1:0] mcnt_q, mcnt_d, duty;
    logic [DW-1:0] dcnt_q, dcnt_d;
    motor_state_e  state_q, state_d;
    logic          dir_q, dir_d, req_dir, mpwm_q, mpwm_d;

    assign mcnt_d = (mcnt_q == MPER_LAST) ? '0 : mcnt_q + 1'b1;

    always_comb begin
        case (forward_backward)
            F1, B1:  duty = DUTY_HALF;
            F2:      duty = DUTY_FULL;
            default: duty = '0;
        endcase
    end

    // A stop request never asks for a reversal.
    assign req_dir = (forward_backward == STOP) ? dir_q : (forward_backward == B1);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dcnt_d  = '0;
        case (state_q)
            M_IDLE: begin
                if (forward_backward != STOP)
                    state_d = (req_dir != dir_q) ? M_DEAD : M_RUN;
            end
            M_RUN: begin
                if (forward_backward == STOP)
                    state_d = M_IDLE;
                else if (req_dir != dir_q)
                    state_d = M_DEAD;
            end
            M_DEAD: begin
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DEAD_LAST) begin
                    dcnt_d  = '0;
                    dir_d   = req_dir;
                    state_d = (forward_backward != STOP) ? M_RUN : M_IDLE;
                end
            end
            default: state_d = M_IDLE;
        endcase
        mpwm_d = (mcnt_q < duty) && (state_q == M_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt_q  <= '0;
            dcnt_q  <= '0;
            state_q <= M_IDLE;
            dir_q   <= 1'b0;
            mpwm_q  <= 1'b0;
        end else begin
            mcnt_q  <= mcnt_d;
            dcnt_q  <= dcnt_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            mpwm_q  <= mpwm_d;
        end
    end

    assign motor_pwm  = mpwm_q;
    assign motor_dir  = dir_q;
    assign fault      = fault_lr | fault_ud;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_actuator_driver.sv
// Directed bench for actuator_driver with small frame/motor periods; expectations hand-derived.
module tb_actuator_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] left_right = 3'b000;
    logic [2:0] up_down = 3'b000;
    logic [1:0] forward_backward = 2'b00;
    logic       servo_lr, servo_ud, motor_pwm, motor_dir, fault, frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ACT_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    always #5 clk = ~clk;

    actuator_driver #(
        .PERIOD_CYC       (100),
        .CENTER_CYC       (50),
        .STEP_CYC         (10),
        .SLEW_CYC         (4),
        .MOTOR_PERIOD_CYC (10),
        .DEADTIME_CYC     (3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .left_right       (left_right),
        .up_down          (up_down),
        .forward_backward (forward_backward),
        .servo_lr         (servo_lr),
        .servo_ud         (servo_ud),
        .motor_pwm        (motor_pwm),
        .motor_dir        (motor_dir),
        .fault            (fault),
        .frame_tick       (frame_tick)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 250 && frame_tick !== 1'b1; i++) @(negedge clk);
        if (frame_tick !== 1'b1) chk("tick_timeout", 0, 1);
    endtask

    // Counts high samples over one frame starting at the frame_tick sample.
    task automatic measure_frame(output int wlr, output int wud, output int ticks);
        wait_tick();
        wlr = 0; wud = 0; ticks = 0;
        for (int i = 0; i < 100; i++) begin
            wlr += int'(servo_lr);
            wud += int'(servo_ud);
            ticks += int'(frame_tick);
            @(negedge clk);
        end
    endtask

    task automatic count_pwm(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            n += int'(motor_pwm);
            @(negedge clk);
        end
    endtask

    function automatic int slew_exp(input int k);
        int v;
        v = 50 - 4 * k;
        if (!SLEW) return 20;
        return (v > 20) ? v : 20;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wlr, wud, tk, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_servo_lr", servo_lr, 0);
        chk("rst_servo_ud", servo_ud, 0);
        chk("rst_motor_pwm", motor_pwm, 0);
        chk("rst_motor_dir", motor_dir, 0);
        chk("rst_fault", fault, 0);
        chk("rst_frame_tick", frame_tick, 0);
        reset = 1'b0;

        // Centered servos, idle motor, one tick per 100 cycles
        @(negedge clk);
        chk("first_tick", frame_tick, 1);
        measure_frame(wlr, wud, tk);
        chk("center_lr", wlr, 50);
        chk("center_ud", wud, 50);
        chk("ticks_per_frame", tk, 1);
        chk("tick_period", frame_tick, 1);
        chk("idle_pwm", motor_pwm, 0);
        chk("idle_fault", fault, 0);

        // L3 held: slew toward 20 (or jump without slew)
        left_right = 3'b011;
        measure_frame(wlr, wud, tk);
        chk("l3_frame0", wlr, 50);
        for (int k = 1; k <= 9; k++) begin
            measure_frame(wlr, wud, tk);
            chk($sformatf("l3_frame%0d", k), wlr, slew_exp(k));
        end

        // Mid-frame change of up_down must not alter the running pulse
        wait_tick();
        wud = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 30) up_down = 3'b110;
            wud += int'(servo_ud);
            @(negedge clk);
        end
        chk("ud_midframe_hold", wud, 50);
        measure_frame(wlr, wud, tk);
        chk("ud_after_tick", wud, SLEW ? 54 : 80);

        // L2, then illegal code: width held, sticky fault
        left_right = 3'b010;
        repeat (6) measure_frame(wlr, wud, tk);
        chk("l2_width", wlr, 30);
        chk("l2_no_fault", fault, 0);
        left_right = 3'b111;
        measure_frame(wlr, wud, tk);
        measure_frame(wlr, wud, tk);
        chk("re_width_held", wlr, 30);
        chk("re_fault", fault, 1);
        left_right = 3'b000;
        measure_frame(wlr, wud, tk);
        measure_frame(wlr, wud, tk);
        chk("s0_after_re_width", wlr, SLEW ? 34 : 50);
        chk("fault_sticky", fault, 1);
        chk("ud_settled", wud, 80);

        // Motor F1 / F2
        forward_backward = 2'b01;
        repeat (3) @(negedge clk);
        count_pwm(n);
        chk("f1_duty", n, 5);
        chk("f1_dir", motor_dir, 0);
        forward_backward = 2'b11;
        repeat (2) @(negedge clk);
        count_pwm(n);
        chk("f2_duty", n, 10);

        // Reversal request withdrawn during dead time
        forward_backward = 2'b10;
        @(negedge clk);
        forward_backward = 2'b01;
        @(negedge clk);
        chk("tog_dead_pwm1", motor_pwm, 0);
        @(negedge clk);
        chk("tog_dead_pwm2", motor_pwm, 0);
        @(negedge clk);
        chk("tog_dead_pwm3", motor_pwm, 0);
        chk("tog_dir_kept", motor_dir, 0);
        repeat (2) @(negedge clk);
        count_pwm(n);
        chk("tog_resume_duty", n, 5);
        chk("tog_dir_final", motor_dir, 0);

        // Real reversal to B1
        forward_backward = 2'b10;
        @(negedge clk);
        chk("b1_dir_before", motor_dir, 0);
        @(negedge clk);
        chk("b1_dead_pwm1", motor_pwm, 0);
        @(negedge clk);
        chk("b1_dead_pwm2", motor_pwm, 0);
        chk("b1_dir_in_dead", motor_dir, 0);
        @(negedge clk);
        chk("b1_dead_pwm3", motor_pwm, 0);
        chk("b1_dir_flipped", motor_dir, 1);
        repeat (2) @(negedge clk);
        count_pwm(n);
        chk("b1_duty", n, 5);
        chk("b1_dir_hold", motor_dir, 1);

        // Reset while running
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rrst_servo_lr", servo_lr, 0);
        chk("rrst_servo_ud", servo_ud, 0);
        chk("rrst_motor_pwm", motor_pwm, 0);
        chk("rrst_motor_dir", motor_dir, 0);
        chk("rrst_fault", fault, 0);
        chk("rrst_frame_tick", frame_tick, 0);
        left_right = 3'b000;
        up_down = 3'b000;
        forward_backward = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        measure_frame(wlr, wud, tk);
        chk("post_rst_lr", wlr, 50);
        chk("post_rst_ud", wud, 50);
        chk("post_rst_fault", fault, 0);
        chk("post_rst_pwm", motor_pwm, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
